pc_fetch_sequencer: RTL and testbench

Owns the architectural PC register and sequences instruction fetch for the RV32 core. It issues one outstanding request at a time to instruction memory over a valid/ready request channel and accepts a valid-only response. It presents the fetched instruction and its PC to decode. It applies PC redirects from execute, where the target is produced under pc_input_sel = PC_INPUT_ALU, and discards stale in-flight fetches.

---
 rtl/pc_fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Owns the architectural PC of the RV32 core and sequences instruction fetch:
// one outstanding request at a time on a valid/ready request channel, a
// valid-only response channel, and a single-entry holding register for decode.
// Execute redirects move the PC and cancel any in-flight or held fetch. A
// misaligned redirect target parks the sequencer in a sticky fault state that
// only reset clears.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-high reset
//   redirect_valid   execute requests a PC change
//   redirect_target  new PC (ALU result)
//   imem_req_valid   fetch request valid
//   imem_req_addr    fetch address (always the current PC)
//   imem_req_ready   memory accepts the request
//   imem_rsp_valid   response data valid
//   imem_rsp_data    fetched instruction word
//   instr_valid      instruction available to decode
//   instr            held instruction
//   instr_pc         PC of the held instruction
//   instr_ready      decode consumes the instruction
//   fetch_fault      sticky misaligned-target fault
//   fault_addr       offending redirect target
module pc_fetch_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_addr
);

    typedef enum logic [2:0] {
        StReq     = 3'd0,
        StWaitRsp = 3'd1,
        StDrop    = 3'd2,
        StHold    = 3'd3,
        StFault   = 3'd4
    } state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_fault;
    logic [XLEN-1:0] r_fault_addr;

    logic            w_redir_ok;
    logic            w_redir_bad;
    logic            w_req_hs;

    assign w_redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign w_redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign w_req_hs    = imem_req_ready;  // request valid is implied by being in StReq

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StReq;
            r_pc         <= RESET_VECTOR;
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else if (r_state != StFault && w_redir_bad) begin
            // Misaligned target wins over everything; pc is left untouched.
            r_state      <= StFault;
            r_fault      <= 1'b1;
            r_fault_addr <= redirect_target;
        end else begin
            unique case (r_state)
                StReq: begin
                    if (w_redir_ok) begin
                        r_pc <= redirect_target;
                        // A request accepted on the old address leaves a stale response.
                        if (w_req_hs) r_state <= StDrop;
                    end else if (w_req_hs) begin
                        r_state <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (w_redir_ok) begin
                        r_pc    <= redirect_target;
                        r_state <= imem_rsp_valid ? StReq : StDrop;
                    end else if (imem_rsp_valid) begin
                        r_instr    <= imem_rsp_data;
                        r_instr_pc <= r_pc;
                        r_pc       <= r_pc + XLEN'(4);
                        r_state    <= StHold;
                    end
                end
                StDrop: begin
                    if (w_redir_ok) r_pc <= redirect_target;
                    if (imem_rsp_valid) r_state <= StReq;
                end
                StHold: begin
                    if (w_redir_ok) begin
                        // Held instruction is on the wrong path; discard it.
                        r_pc    <= redirect_target;
                        r_state <= StReq;
                    end else if (instr_ready) begin
                        r_state <= StReq;
                    end
                end
                StFault: begin
                    r_state <= StFault;
                end
                default: begin
                    r_state <= StReq;
                end
            endcase
        end
    end

    // Gated by reset so nothing is presented while reset is held.
    assign imem_req_valid = (r_state == StReq) && !reset;
    assign instr_valid    = (r_state == StHold) && !reset;
    assign imem_req_addr  = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign fetch_fault    = r_fault;
    assign fault_addr     = r_fault_addr;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_fault;
    logic [31:0] fault_addr;

    pc_fetch_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (RV)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .fetch_fault     (fetch_fault),
        .fault_addr      (fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        held;
    logic [31:0] exp_pc;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From StReq at exp_pc: optional ready stall, handshake, response next cycle,
    // then check the held instruction against the scoreboard.
    task automatic to_hold(input logic [31:0] data, input int stall);
        chk("req_valid", {31'b0, imem_req_valid}, 1);
        chk("req_addr", imem_req_addr, exp_pc);
        for (int i = 0; i < stall; i++) begin
            imem_req_ready = 1'b0;
            step();
            chk("stall_valid", {31'b0, imem_req_valid}, 1);
            chk("stall_addr", imem_req_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_no_req", {31'b0, imem_req_valid}, 0);
        chk("wait_no_instr", {31'b0, instr_valid}, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        sb.push_back('{pc: exp_pc, data: data});
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        chk("hold_valid", {31'b0, instr_valid}, 1);
        chk("hold_no_req", {31'b0, imem_req_valid}, 0);
        chk("sb_pending", {31'b0, (sb.size() != 0)}, 1);
        if (sb.size() != 0) begin
            held = sb.pop_front();
            chk("instr_pc", instr_pc, held.pc);
            chk("instr", instr, held.data);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    // Keep decode stalled for some cycles, then consume; next request follows.
    task automatic release_hold(input int stall);
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            step();
            chk("stall_hold_valid", {31'b0, instr_valid}, 1);
            chk("stall_hold_pc", instr_pc, held.pc);
            chk("stall_hold_instr", instr, held.data);
            chk("stall_hold_no_req", {31'b0, imem_req_valid}, 0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("post_instr_valid", {31'b0, instr_valid}, 0);
        chk("next_req_valid", {31'b0, imem_req_valid}, 1);
        chk("next_req_addr", imem_req_addr, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        instr_ready     = 1'b0;
        exp_pc          = RV;

        // Reset state
        step();
        step();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 0);
        chk("rst_fault", {31'b0, fetch_fault}, 0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        reset = 1'b0;
        #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 1);
        chk("first_req_addr", imem_req_addr, RV);

        // Three back-to-back fetches at peak rate
        for (int k = 0; k < 3; k++) begin
            to_hold(32'h1300_0000 | exp_pc, 0);
            release_hold(0);
        end

        // Request and decode backpressure
        to_hold(32'hCAFE_0000 | exp_pc, 3);
        release_hold(4);

        // Redirect in WAIT_RSP without response: stale DEADBEEF must vanish
        chk("w_req_valid", {31'b0, imem_req_valid}, 1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("drop_no_req", {31'b0, imem_req_valid}, 0);
        chk("drop_addr", imem_req_addr, 32'h200);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("drop_no_instr", {31'b0, instr_valid}, 0);
        chk("redir_req_valid", {31'b0, imem_req_valid}, 1);
        chk("redir_req_addr", imem_req_addr, 32'h200);
        exp_pc = 32'h200;

        // Redirect in HOLD with instr_ready in the same cycle
        to_hold(32'hAAAA_0200, 0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        instr_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        chk("hold_redir_no_instr", {31'b0, instr_valid}, 0);
        chk("hold_redir_req", {31'b0, imem_req_valid}, 1);
        chk("hold_redir_addr", imem_req_addr, 32'h300);
        exp_pc = 32'h300;
        to_hold(32'hBBBB_0300, 0);
        release_hold(1);

        // Redirect coinciding with a request handshake
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("req_hs_redir_drop", {31'b0, imem_req_valid}, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_5555;
        step();
        imem_rsp_valid = 1'b0;
        chk("req_hs_redir_instr", {31'b0, instr_valid}, 0);
        chk("req_hs_redir_addr", imem_req_addr, 32'h40);
        exp_pc = 32'h40;

        // PC wrap: redirect in REQ without handshake, then complete the fetch
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        to_hold(32'h7777_7777, 0);
        release_hold(0);
        chk("wrap_addr", imem_req_addr, 32'h0);

        // Misaligned redirect: sticky fault until reset
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0402;
        step();
        chk("fault_set", {31'b0, fetch_fault}, 1);
        chk("fault_addr", fault_addr, 32'h402);
        chk("fault_no_req", {31'b0, imem_req_valid}, 0);
        chk("fault_pc_kept", imem_req_addr, exp_pc);
        redirect_target = 32'h500;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b1;
        instr_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fault_stuck_no_req", {31'b0, imem_req_valid}, 0);
            chk("fault_stuck_no_instr", {31'b0, instr_valid}, 0);
            chk("fault_stuck_flag", {31'b0, fetch_fault}, 1);
            chk("fault_stuck_addr", fault_addr, 32'h402);
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        reset = 1'b1;
        step();
        chk("fault_rst_no_req", {31'b0, imem_req_valid}, 0);
        chk("fault_rst_clear", {31'b0, fetch_fault}, 0);
        chk("fault_rst_addr", fault_addr, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_req", {31'b0, imem_req_valid}, 1);
        chk("post_rst_addr", imem_req_addr, RV);
        exp_pc = RV;
        to_hold(32'h0101_0101, 0);
        release_hold(0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
